soc_system_hex_bank_pio: RTL and testbench



---
 rtl/soc_system_hex_bank_pio_if.sv | 14 +
 rtl/soc_system_hex_bank_pio.sv | 176 +++++++++++++++++
 tb/tb_soc_system_hex_bank_pio.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/soc_system_hex_bank_pio_if.sv
// Avalon-MM slave bundle for the seven-segment bank PIO (zero-latency reads, no wait states).
interface soc_system_hex_bank_pio_if;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 32;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/soc_system_hex_bank_pio.sv
// Bank of active-low seven-segment digits with packed-nibble writes, optional hex decode and blink.
// Blink engine, BLINK_MASK and CTRL.BLINK are built only when HEX_BANK_BLINK_EN is defined.
module soc_system_hex_bank_pio #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned SEG_W      = 7,
  parameter int unsigned BLINK_DIV  = 25000000
) (
  input  logic                          clk,
  input  logic                          reset,
  soc_system_hex_bank_pio_if.slave      bus,
  output logic [NUM_DIGITS*SEG_W-1:0]   out_port
);
  localparam int unsigned OUT_W = NUM_DIGITS * SEG_W;
  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_MASK   = 4'h1;
  localparam logic [3:0] ADDR_PACKED = 4'h2;
  localparam logic [3:0] ADDR_STATUS = 4'h3;

  typedef logic [NUM_DIGITS-1:0][SEG_W-1:0] digits_t;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h40;  4'h1: g = 7'h79;  4'h2: g = 7'h24;  4'h3: g = 7'h30;
      4'h4: g = 7'h19;  4'h5: g = 7'h12;  4'h6: g = 7'h02;  4'h7: g = 7'h78;
      4'h8: g = 7'h00;  4'h9: g = 7'h10;  4'hA: g = 7'h08;  4'hB: g = 7'h03;
      4'hC: g = 7'h46;  4'hD: g = 7'h21;  4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  logic                  wr_c;
  logic                  dec_q, dec_d;
  digits_t               digit_q, digit_d;
  logic [OUT_W-1:0]      out_q, out_d;
  logic                  blink_c;
  logic [NUM_DIGITS-1:0] mask_c;
  logic                  phase_c;
  logic                  unused_wdata;

  assign wr_c         = bus.chipselect && !bus.write_n;
  assign unused_wdata = ^bus.writedata;

`ifdef HEX_BANK_BLINK_EN
  localparam int unsigned CNT_W = $clog2(BLINK_DIV);

  logic                  blink_q, blink_d;
  logic [NUM_DIGITS-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  phase_q, phase_d;
`else
  localparam int unsigned unused_blink_div = BLINK_DIV;
`endif

  // Register file next-state from bus writes
  always_comb begin
    dec_d   = dec_q;
    digit_d = digit_q;
`ifdef HEX_BANK_BLINK_EN
    blink_d = blink_q;
    mask_d  = mask_q;
`endif
    if (wr_c) begin
      case (bus.address)
        ADDR_CTRL: begin
          dec_d = bus.writedata[0];
`ifdef HEX_BANK_BLINK_EN
          blink_d = bus.writedata[1];
`endif
        end
`ifdef HEX_BANK_BLINK_EN
        ADDR_MASK: mask_d = bus.writedata[NUM_DIGITS-1:0];
`endif
        ADDR_PACKED: begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_d[i] = SEG_W'(bus.writedata[4*i +: 4]);
          end
        end
        default: begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bus.address == 4'(8 + i)) digit_d[i] = bus.writedata[SEG_W-1:0];
          end
        end
      endcase
    end
  end

`ifdef HEX_BANK_BLINK_EN
  // Enabling (or disabling) blink restarts from counter 0 in the on phase
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!blink_d || !blink_q) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == CNT_W'(BLINK_DIV - 1)) begin
      cnt_d   = '0;
      phase_d = !phase_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign blink_c = blink_q;
  assign mask_c  = mask_q;
  assign phase_c = phase_q;
`else
  assign blink_c = 1'b0;
  assign mask_c  = '0;
  assign phase_c = 1'b1;
`endif

  // Segment generation: blank beats decode beats raw
  always_comb begin : seg_gen
    logic [SEG_W-1:0] seg;
    out_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      seg = digit_q[i];
      if (blink_c && mask_c[i] && !phase_c) begin
        seg = '1;
      end else if (dec_q) begin
        seg      = '1;
        seg[6:0] = glyph(digit_q[i][3:0]);
      end
      out_d[i*SEG_W +: SEG_W] = seg;
    end
  end

  // Zero-latency read mux; a same-cycle write is not yet visible
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_CTRL:   bus.readdata = {30'b0, blink_c, dec_q};
      ADDR_MASK:   bus.readdata = 32'(mask_c);
      ADDR_PACKED: begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          bus.readdata[4*i +: 4] = digit_q[i][3:0];
        end
      end
      ADDR_STATUS: bus.readdata = {31'b0, phase_c};
      default: begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (bus.address == 4'(8 + i)) bus.readdata = 32'(digit_q[i]);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dec_q   <= 1'b0;
      digit_q <= '1;
      out_q   <= '1;
`ifdef HEX_BANK_BLINK_EN
      blink_q <= 1'b0;
      mask_q  <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b1;
`endif
    end else begin
      dec_q   <= dec_d;
      digit_q <= digit_d;
      out_q   <= out_d;
`ifdef HEX_BANK_BLINK_EN
      blink_q <= blink_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
`endif
    end
  end

  assign out_port = out_q;

endmodule

// File: tb/tb_soc_system_hex_bank_pio.sv
// Scoreboard bench for soc_system_hex_bank_pio: directed then random bus traffic against a
// cycle-count based reference model; works with or without HEX_BANK_BLINK_EN.
module tb_soc_system_hex_bank_pio;
  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned BLINK_DIV  = 4;
  localparam int unsigned OUT_W      = NUM_DIGITS * SEG_W;
`ifdef HEX_BANK_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif
  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic             clk = 1'b0;
  logic             reset;
  logic [OUT_W-1:0] out_port;

  soc_system_hex_bank_pio_if bus();

  soc_system_hex_bank_pio #(
    .NUM_DIGITS(NUM_DIGITS),
    .SEG_W     (SEG_W),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .out_port(out_port)
  );

  always #5 clk = ~clk;

  // Reference model state: blink phase derived from cycles elapsed since enabling
  bit          m_dec;
  bit          m_blink;
  logic [5:0]  m_mask;
  logic [6:0]  m_dig [NUM_DIGITS];
  int unsigned m_since;

  // Operation currently presented on the bus (sampled at the next edge)
  logic        c_rst, c_cs, c_wn;
  logic [3:0]  c_addr;
  logic [31:0] c_wd;

  typedef struct {
    logic [31:0]      rd;
    logic [OUT_W-1:0] out;
    logic [3:0]       addr;
    int               cyc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  function automatic bit m_phase();
    return !m_blink || (((m_since / BLINK_DIV) % 2) == 0);
  endfunction

  function automatic logic [OUT_W-1:0] m_segs();
    logic [OUT_W-1:0] r;
    logic [6:0]       s;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (m_blink && m_mask[i] && !m_phase()) s = 7'h7F;
      else if (m_dec)                          s = GLYPH[m_dig[i][3:0]];
      else                                     s = m_dig[i];
      r[i*SEG_W +: SEG_W] = s;
    end
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] a);
    logic [31:0] r;
    int          idx;
    r   = 32'd0;
    idx = int'(a) - 8;
    case (a)
      4'h0: r = {30'd0, m_blink, m_dec};
      4'h1: r = {26'd0, m_mask};
      4'h2: for (int i = 0; i < NUM_DIGITS; i++) r[4*i +: 4] = m_dig[i][3:0];
      4'h3: r = {31'd0, m_phase()};
      default: if (idx >= 0 && idx < NUM_DIGITS) r = {25'd0, m_dig[idx]};
    endcase
    return r;
  endfunction

  task automatic m_apply();
    bit nb;
    int idx;
    if (c_rst) begin
      m_dec   = 1'b0;
      m_blink = 1'b0;
      m_mask  = 6'd0;
      m_since = 0;
      for (int i = 0; i < NUM_DIGITS; i++) m_dig[i] = 7'h7F;
      return;
    end
    nb  = m_blink;
    idx = int'(c_addr) - 8;
    if (c_cs && !c_wn) begin
      case (c_addr)
        4'h0: begin
          m_dec = c_wd[0];
          if (BLINK_EN) nb = c_wd[1];
        end
        4'h1: if (BLINK_EN) m_mask = c_wd[5:0];
        4'h2: for (int i = 0; i < NUM_DIGITS; i++) m_dig[i] = {3'b000, c_wd[4*i +: 4]};
        default: if (idx >= 0 && idx < NUM_DIGITS) m_dig[idx] = c_wd[6:0];
      endcase
    end
    m_since = (nb && m_blink) ? m_since + 1 : 0;
    m_blink = nb;
  endtask

  // One bus cycle: advance the model over the edge, then present the next operation
  task automatic step(input logic r, input logic cs, input logic wn,
                      input logic [3:0] a, input logic [31:0] d);
    logic [OUT_W-1:0] o;
    exp_t             e;
    @(posedge clk);
    cyc++;
    o = c_rst ? {OUT_W{1'b1}} : m_segs();
    m_apply();
    #1;
    reset          = r;
    bus.chipselect = cs;
    bus.write_n    = wn;
    bus.address    = a;
    bus.writedata  = d;
    c_rst = r; c_cs = cs; c_wn = wn; c_addr = a; c_wd = d;
    e.rd   = m_read(a);
    e.out  = o;
    e.addr = a;
    e.cyc  = cyc;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    step(1'b0, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [3:0] a);
    step(1'b0, 1'b1, 1'b1, a, $urandom);
  endtask

  // Monitor: compare the oldest expectation against the DUT mid-cycle
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (bus.readdata !== e.rd) begin
          failures++;
          $display("FAIL readdata cyc=%0d addr=%h got=%h exp=%h", e.cyc, e.addr, bus.readdata, e.rd);
        end
        checks++;
        if (out_port !== e.out) begin
          failures++;
          $display("FAIL out_port cyc=%0d got=%h exp=%h", e.cyc, out_port, e.out);
        end
      end
    end
  end

  initial begin : stimulus
    logic [3:0] a;
    reset          = 1'b1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 4'h0;
    bus.writedata  = 32'd0;
    c_rst = 1'b1; c_cs = 1'b0; c_wn = 1'b1; c_addr = 4'h0; c_wd = 32'd0;

    step(1'b1, 1'b0, 1'b1, 4'h0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 4'h0, 32'd0);
    for (int i = 0; i < 16; i++) rd(4'(i));

    wr(4'hA, 32'h24);
    rd(4'hA);
    rd(4'hA);

    wr(4'h0, 32'h1);
    wr(4'h2, 32'h00A5_3210);
    rd(4'h2);
    rd(4'h2);

    wr(4'h1, 32'h1);
    wr(4'h0, 32'h3);
    for (int i = 0; i < 20; i++) rd(4'h3);
    wr(4'h0, 32'h3);
    for (int i = 0; i < 6; i++) rd(4'h3);

    wr(4'h5, $urandom);
    wr(4'hF, $urandom);
    rd(4'h5);
    rd(4'hF);
    for (int i = 0; i < NUM_DIGITS; i++) rd(4'(8 + i));

    for (int i = 0; i < 2 * BLINK_DIV && m_phase(); i++) rd(4'h3);
    step(1'b1, 1'b1, 1'b0, 4'hA, 32'h55);
    rd(4'h0);
    rd(4'h3);
    rd(4'hA);

    wr(4'h0, 32'h3);
    rd(4'h0);
    rd(4'h0);

    for (int n = 0; n < 2000; n++) begin
      a = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           a, $urandom);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 4'h0, 32'd0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #2;
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
